mem_arbiter: RTL

- Shares the single-port 4 KiB system RAM between CPU, GPU sprite engine and display scanout.
- Each requester keeps its existing interface:
  - read: level request, held until a one-cycle ack that carries the byte;
  - write: a one-cycle fire-and-forget strobe.
- Per-port 1-deep write buffers absorb writes that arrive while another port owns the RAM.
- Sits between the requesters and the RAM macro (synchronous read, 1-cycle latency).

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter_rr_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the system-RAM arbiter.
// Port numbering, default widths and the write-buffer entry layout.
package mem_arb_pkg;

    localparam int PORT_CPU  = 0;
    localparam int PORT_GPU  = 1;
    localparam int PORT_DISP = 2;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } wbuf_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side signals of the arbiter.
// master = requesters plus RAM macro, slave = the arbiter.
interface mem_arbiter_if #(
    parameter int NPORTS = 3,
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
);
    logic [NPORTS-1:0]        rd_req;
    logic [NPORTS*ADDR_W-1:0] rd_idx;
    logic [NPORTS-1:0]        rd_ack;
    logic [DATA_W-1:0]        rd_byte;
    logic [NPORTS-1:0]        wr;
    logic [NPORTS*ADDR_W-1:0] wr_idx;
    logic [NPORTS*DATA_W-1:0] wr_byte;
    logic                     wr_overflow;
    logic [ADDR_W-1:0]        ram_addr;
    logic                     ram_we;
    logic [DATA_W-1:0]        ram_wdata;
    logic [DATA_W-1:0]        ram_rdata;

    modport master (
        output rd_req, rd_idx, wr, wr_idx, wr_byte, ram_rdata,
        input  rd_ack, rd_byte, wr_overflow, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  rd_req, rd_idx, wr, wr_idx, wr_byte, ram_rdata,
        output rd_ack, rd_byte, wr_overflow, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// returned both one-hot and as an index.
module rr_pick #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    always_comb begin
        int j;
        // NOTE: every output gets a default before the search so no path
        // leaves a value held over, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: buffered writes first, then round-robin reads.
// Optional MEM_ARB_PERF_EN adds per-port grant and stall counters.
module mem_arbiter #(
    parameter  int NPORTS = 3,
    parameter  int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter  int DATA_W = mem_arb_pkg::DATA_W,
    localparam int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [NPORTS*16-1:0] perf_grants,
    output logic [NPORTS*16-1:0] perf_stall
`endif
);
    import mem_arb_pkg::*;

    wbuf_t             buf_q [NPORTS];
    logic [PW-1:0]     wptr_q, rptr_q, fl_port_q;
    logic              fl_valid_q, ovf_q;

    logic [NPORTS-1:0] wvalid, wgrant, rreq, rgrant, drain;
    logic [PW-1:0]     widx, ridx;
    logic              wany, rany, issue;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
        return (i == PW'(NPORTS - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        for (int p = 0; p < NPORTS; p++) wvalid[p] = buf_q[p].valid;
    end

    // The port whose read is in flight cannot be granted again until acked.
    assign rreq = bus.rd_req & ~((fl_valid_q ? NPORTS'(1) : '0) << fl_port_q);

    rr_pick #(.N(NPORTS)) u_wpick (.req(wvalid), .ptr(wptr_q), .grant(wgrant), .idx(widx), .any(wany));
    rr_pick #(.N(NPORTS)) u_rpick (.req(rreq),   .ptr(rptr_q), .grant(rgrant), .idx(ridx), .any(rany));

    // A write strobed this cycle blocks reads so a same-cycle read sees it.
    always_comb begin
        drain         = '0;
        issue         = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (!reset) begin
            if (wany) begin
                drain         = wgrant;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = buf_q[widx].idx;
                bus.ram_wdata = buf_q[widx].data;
            end else if (rany && !(|bus.wr)) begin
                issue        = 1'b1;
                bus.ram_addr = bus.rd_idx[ridx*ADDR_W +: ADDR_W];
            end
        end
    end

    // Reset masks the ack so a read issued just before reset is never reported.
    assign bus.rd_ack      = (fl_valid_q && !reset) ? (NPORTS'(1) << fl_port_q) : '0;
    assign bus.rd_byte     = bus.ram_rdata;
    assign bus.wr_overflow = ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the buffer array is reset because its valid bits are
            // control state; pure data storage would not need a reset.
            for (int p = 0; p < NPORTS; p++) buf_q[p] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fl_valid_q <= 1'b0;
            fl_port_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update
            // based on the pre-edge values, independent of statement order.
            for (int p = 0; p < NPORTS; p++) begin
                if (bus.wr[p]) begin
                    if (!buf_q[p].valid || drain[p])
                        buf_q[p] <= '{valid: 1'b1,
                                      idx:   bus.wr_idx[p*ADDR_W +: ADDR_W],
                                      data:  bus.wr_byte[p*DATA_W +: DATA_W]};
                    else
                        ovf_q <= 1'b1;
                end else if (drain[p]) begin
                    buf_q[p].valid <= 1'b0;
                end
            end
            if (|drain) wptr_q <= nxt(widx);
            if (issue)  rptr_q <= nxt(ridx);
            fl_valid_q <= issue;
            fl_port_q  <= ridx;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [15:0] grant_cnt [NPORTS];
    logic [15:0] stall_cnt [NPORTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                grant_cnt[p] <= '0;
                stall_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if ((drain[p] || (issue && rgrant[p])) && grant_cnt[p] != 16'hFFFF)
                    grant_cnt[p] <= grant_cnt[p] + 16'd1;
                if (bus.rd_req[p] && !(issue && rgrant[p]) && !bus.rd_ack[p] &&
                    stall_cnt[p] != 16'hFFFF)
                    stall_cnt[p] <= stall_cnt[p] + 16'd1;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            perf_grants[p*16 +: 16] = grant_cnt[p];
            perf_stall[p*16 +: 16]  = stall_cnt[p];
        end
    end
`endif

endmodule
